// File: rtl/phv_in_port.sv
`default_nettype none
// ============================================================================
// phv_in_port : assembles a beat stream into a flat PHV with a one-cycle pulse
// Revision    : 1.0
// ============================================================================
module phv_in_port #(
    parameter int PHV_BYTES  = 128,
    parameter int BEAT_BYTES = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [8*BEAT_BYTES-1:0] io_in_data,
    input  logic                    io_in_valid,
    input  logic                    io_in_last,
    output logic                    io_in_ready,
    output logic [8*PHV_BYTES-1:0]  io_phv_out_data,
    output logic                    io_phv_out_valid,
    output logic                    io_phv_out_trunc
);

    localparam int BEATS  = PHV_BYTES / BEAT_BYTES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_W = 8 * BEAT_BYTES;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DROP    = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_drop;
    logic [8*PHV_BYTES-1:0] r_buf;

    logic                   w_accept;
    logic                   w_wr_en;
    logic                   w_cnt_inc;
    logic                   w_drop_set;

    assign w_accept = io_in_valid && io_in_ready;

    always_comb begin
        w_state_next     = r_state;
        io_in_ready      = 1'b1;
        io_phv_out_valid = 1'b0;
        io_phv_out_trunc = 1'b0;
        w_wr_en          = 1'b0;
        w_cnt_inc        = 1'b0;
        w_drop_set       = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (w_accept) begin
                    w_wr_en = 1'b1;
                    if (io_in_last)
                        w_state_next = ST_EMIT;
                    else if (r_cnt == CNT_W'(BEATS - 1))
                        w_state_next = ST_DROP;
                    else
                        w_cnt_inc = 1'b1;
                end
            end
            ST_DROP: begin
                if (w_accept) begin
                    w_drop_set = 1'b1;
                    if (io_in_last)
                        w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                io_in_ready      = 1'b0;
                io_phv_out_valid = 1'b1;
                io_phv_out_trunc = r_drop;
                w_state_next     = ST_COLLECT;
            end
            default: w_state_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_COLLECT;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_EMIT) begin
                r_cnt  <= '0;
                r_drop <= 1'b0;
            end else begin
                if (w_cnt_inc)
                    r_cnt <= r_cnt + 1'b1;
                if (w_drop_set)
                    r_drop <= 1'b1;
            end
        end
    end

    // Buffer is cleared after every emit so short headers leave zero padding.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_buf <= '0;
        end else if (r_state == ST_EMIT) begin
            r_buf <= '0;
        end else begin
            for (int b = 0; b < BEATS; b++) begin
                if (w_wr_en && (r_cnt == CNT_W'(b)))
                    r_buf[BEAT_W*b +: BEAT_W] <= io_in_data;
            end
        end
    end

    assign io_phv_out_data = r_buf;

endmodule
`default_nettype wire

// File: tb/tb_phv_in_port.sv
`default_nettype none
// ============================================================================
// tb_phv_in_port : header table + scoreboard bench for phv_in_port
// Revision       : 1.0
// ============================================================================
module tb_phv_in_port;

    localparam int PHV_BYTES  = 128;
    localparam int BEAT_BYTES = 8;
    localparam int BEATS      = PHV_BYTES / BEAT_BYTES;

    logic          clock = 1'b0;
    logic          reset;
    logic [63:0]   in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [1023:0] phv_data;
    logic          phv_valid;
    logic          phv_trunc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int   nbeats;
        int   kind;
        bit   gap;
        logic exp_trunc;
    } vec_t;

    typedef struct {
        logic [1023:0] data;
        logic          trunc;
        int            cyc;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[12];

    phv_in_port #(.PHV_BYTES(PHV_BYTES), .BEAT_BYTES(BEAT_BYTES)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_in_data       (in_data),
        .io_in_valid      (in_valid),
        .io_in_last       (in_last),
        .io_in_ready      (in_ready),
        .io_phv_out_data  (phv_data),
        .io_phv_out_valid (phv_valid),
        .io_phv_out_trunc (phv_trunc)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    task automatic check_phv(input string name, input logic [1023:0] got, input logic [1023:0] exp);
        logic [7:0] gb;
        logic [7:0] eb;
        checks++;
        if (got !== exp) begin
            failures++;
            for (int i = 0; i < PHV_BYTES; i++) begin
                gb = got[8*i +: 8];
                eb = exp[8*i +: 8];
                if (gb !== eb) begin
                    $display("FAIL %s t=%0t byte=%0d got=%h exp=%h", name, $time, i, gb, eb);
                    break;
                end
            end
        end
    endtask

    // Per-cycle monitor: a pulse is expected exactly in the cycle after the last beat's edge.
    always @(negedge clock) begin
        if (!reset) begin
            automatic bit exp_v = (sbq.size() > 0) && (sbq[0].cyc == cyc);
            check_bit("out_valid", phv_valid, exp_v);
            check_bit("in_ready", in_ready, !exp_v);
            if (exp_v) begin
                if (phv_valid) begin
                    check_phv("phv_data", phv_data, sbq[0].data);
                    check_bit("phv_trunc", phv_trunc, sbq[0].trunc);
                end
                void'(sbq.pop_front());
            end
        end
    end

    function automatic logic [63:0] beat_data(input int kind, input int k);
        logic [7:0] b;
        b = 8'(k);
        case (kind)
            0:       return {8{b}};
            1:       return 64'h0807060504030201;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic l, output bit ok);
        int n;
        n  = 0;
        ok = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        while (n < 100) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1;
                @(posedge clock);
                #1;
                break;
            end
            @(posedge clock);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout t=%0t got=no_accept exp=accept", $time);
        end
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        in_data  = {$urandom, $urandom};
        @(posedge clock);
        #1;
    endtask

    task automatic send_header(input vec_t v);
        logic [1023:0] exp;
        logic [63:0]   d;
        bit            ok;
        exp = '0;
        for (int k = 0; k < v.nbeats; k++) begin
            if (v.gap && ($urandom_range(0, 1) == 1))
                idle_cycle();
            d = beat_data(v.kind, k);
            if (k < BEATS)
                exp[64*k +: 64] = d;
            send_beat(d, k == v.nbeats - 1, ok);
            if (ok && (k == v.nbeats - 1))
                sbq.push_back('{data: exp, trunc: v.exp_trunc, cyc: cyc});
        end
    endtask

    initial begin
        bit ok;
        tbl[0]  = '{nbeats: 16, kind: 0, gap: 0, exp_trunc: 1'b0};
        tbl[1]  = '{nbeats: 3,  kind: 1, gap: 0, exp_trunc: 1'b0};
        tbl[2]  = '{nbeats: 1,  kind: 2, gap: 0, exp_trunc: 1'b0};
        tbl[3]  = '{nbeats: 20, kind: 2, gap: 0, exp_trunc: 1'b1};
        tbl[4]  = '{nbeats: 4,  kind: 2, gap: 0, exp_trunc: 1'b0};
        tbl[5]  = '{nbeats: 16, kind: 2, gap: 1, exp_trunc: 1'b0};
        tbl[6]  = '{nbeats: 7,  kind: 2, gap: 1, exp_trunc: 1'b0};
        tbl[7]  = '{nbeats: 17, kind: 2, gap: 1, exp_trunc: 1'b1};
        tbl[8]  = '{nbeats: 1,  kind: 2, gap: 0, exp_trunc: 1'b0};
        tbl[9]  = '{nbeats: 1,  kind: 2, gap: 0, exp_trunc: 1'b0};
        tbl[10] = '{nbeats: 1,  kind: 2, gap: 0, exp_trunc: 1'b0};
        tbl[11] = '{nbeats: 1,  kind: 2, gap: 0, exp_trunc: 1'b0};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clock);
        #1;
        check_bit("rst_ready", in_ready, 1'b1);
        check_bit("rst_valid", phv_valid, 1'b0);
        check_bit("rst_trunc", phv_trunc, 1'b0);
        check_phv("rst_data", phv_data, '0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int t = 0; t < 12; t++)
            send_header(tbl[t]);

        // Abort a partial header with an asynchronous reset in mid-cycle.
        for (int k = 0; k < 5; k++)
            send_beat({$urandom | 32'h1, $urandom}, 1'b0, ok);
        #2;
        reset = 1'b1;
        #1;
        check_bit("midrst_ready", in_ready, 1'b1);
        check_bit("midrst_valid", phv_valid, 1'b0);
        check_bit("midrst_trunc", phv_trunc, 1'b0);
        check_phv("midrst_data", phv_data, '0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        send_header('{nbeats: 2, kind: 2, gap: 0, exp_trunc: 1'b0});

        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d exp=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
